store_buffer: RTL and testbench
===============================

# store_buffer

Parametrised store buffer between the MEM stage and the data-memory write port. It formats byte, half and word stores into lane-aligned data and byte strobes, and drops stores that the MEM stage cancels on an exception. Accepted stores are queued in a DEPTH-entry FIFO and drained in order over a valid/ack handshake. A load-hazard check tells the pipeline when a load overlaps a pending store.

## Interface
- DATA_W, 32: memory port width in bits; 32 or 64.
- ADDR_W, 32: address width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- st_valid  in  1  store request from MEM stage (DMWr).
- st_cancel  in  1  MEM-stage exception present; suppresses the store.
- st_type  in  2  0 = word, 1 = half, 2 = byte, 3 = reserved.
- st_addr  in  ADDR_W  byte address.
- st_wdata  in  DATA_W  store data, right-justified.
- st_ready  out  1  buffer can accept (not full).
- st_err  out  1  one-cycle pulse: misaligned or reserved store rejected.
- mem_req  out  1  head entry valid on the memory port.
- mem_addr  out  ADDR_W  head address, aligned to DATA_W/8.
- mem_wstrb  out  DATA_W/8  head byte strobes.
- mem_wdata  out  DATA_W  head lane-aligned data.
- mem_ack  in  1  memory accepted the head this cycle.
- ld_addr  in  ADDR_W  address of the load in MEM.
- ld_hit  out  1  a pending or incoming store covers ld_addr's aligned word.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Accept when st_valid & st_ready & !st_cancel & aligned & st_type != 3.
- off = st_addr[log2(DATA_W/8)-1:0].
- Byte store: strb = 1<<off; data = st_wdata[7:0] << 8*off.
- Half store: strb = 2'b11<<off; data = st_wdata[15:0] << 8*off.
- Word store: strb = 4'hF<<off; data = st_wdata[31:0] << 8*off.
- Unused lanes are zero in both data and strobe.
- Misaligned store: half with off[0] set, or word with off[1:0] nonzero.
- Misaligned or reserved stores are not enqueued; st_err pulses for one cycle. When st_cancel is high, st_err stays 0 and the store is silently dropped.
- FIFO has head/tail pointers with wrap-around modulo DEPTH.
- Port FSM:
  - IDLE: count == 0, mem_req = 0.
  - REQ: head presented. mem_req, mem_addr, mem_wstrb and mem_wdata hold stable until mem_ack.
  - On ack, the head pops. The FSM stays in REQ if entries remain, otherwise returns to IDLE.
- ld_hit: combinational compare of ld_addr aligned to DATA_W/8 against every valid entry and against a store being accepted this cycle.

## Timing
- Reset values: count = 0, st_ready = 1, mem_req = 0, mem_addr/mem_wstrb/mem_wdata = 0, st_err = 0, pointers = 0. ld_hit is 0 with no store in flight.
- Enqueue-to-mem_req latency is 1 cycle from empty.
- Back-to-back drain: one entry per cycle while mem_ack stays high.
- st_ready = !full, registered from count. A store is never accepted while full, even when mem_ack arrives in the same cycle.
- Enqueue and dequeue in the same cycle leave count unchanged.
- Reset asserted mid-drain: queue discarded, mem_req drops immediately (asynchronous).

## Configuration
- STORE_BUF_MERGE_EN defined: an accepted store merges into the youngest entry when that entry has the same aligned address and is not the head.
  - Merge ORs the strobes and overwrites data bytes under the new strobe.
  - count is unchanged by a merge.
- Macro undefined: every accepted store takes a new entry.

## Structure
- Shared package store_buf_pkg holds:
  - st_type constants ST_WORD, ST_HALF, ST_BYTE, ST_RSVD.
  - The entry struct typedef (addr, strb, data), parametrised through localparams.
- Sub-module store_fmt: combinational formatter producing strb, data and misalign from type, address and data. Instantiated once.

## Test plan
- Byte store at 0x1003, data 0xAB (DATA_W=32) -> next cycle mem_req=1, mem_addr=0x1000, mem_wstrb=4'b1000, mem_wdata=0xAB000000. After mem_ack: count=0, mem_req=0.
- Five word stores with mem_ack=0 -> st_ready=0 after the fourth, fifth not accepted. Then hold mem_ack=1 -> four writes in order on consecutive cycles.
- Half store at 0x2001 -> st_err one cycle, count unchanged. Byte store with st_cancel=1 -> no enqueue, st_err=0.
- Pending store at 0x3004, ld_addr=0x3006 -> ld_hit=1. After that entry is acked -> ld_hit=0.
- Head at 0x100 held (mem_ack=0). Store byte 0x11 to 0x204, then byte 0x22 to 0x205:
  - With STORE_BUF_MERGE_EN: count=2, second entry strb=4'b0011, data=0x00002211.
  - Without: count=3.
- Assert reset with 3 entries queued -> mem_req=0 and count=0 immediately. After release, a new store drains normally.

Source files
------------

// File: rtl/store_buf_pkg.sv
// rtl/store_buf_pkg.sv - shared store types, constants and default entry layout for store_buffer
package store_buf_pkg;

    localparam logic [1:0] ST_WORD = 2'd0;
    localparam logic [1:0] ST_HALF = 2'd1;
    localparam logic [1:0] ST_BYTE = 2'd2;
    localparam logic [1:0] ST_RSVD = 2'd3;

    localparam int SB_DATA_W = 32;
    localparam int SB_ADDR_W = 32;
    localparam int SB_STRB_W = SB_DATA_W / 8;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_STRB_W-1:0] strb;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    typedef enum logic {
        PORT_IDLE = 1'b0,
        PORT_REQ  = 1'b1
    } port_state_e;

endpackage

// File: rtl/store_fmt.sv
// rtl/store_fmt.sv - formats a byte/half/word store into lane-aligned data and strobes
module store_fmt
    import store_buf_pkg::*;
#(
    parameter int DATA_W = SB_DATA_W
) (
    input  logic [1:0]                   st_type,
    input  logic [$clog2(DATA_W/8)-1:0]  off,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W/8-1:0]          strb,
    output logic [DATA_W-1:0]            data,
    output logic                         misalign,
    output logic                         rsvd
);

    localparam int STRB_W = DATA_W / 8;

    logic [STRB_W-1:0] base_strb;
    logic [DATA_W-1:0] base_data;

    always_comb begin
        base_strb = '0;
        base_data = '0;
        misalign  = 1'b0;
        rsvd      = 1'b0;
        case (st_type)
            ST_BYTE: begin
                base_strb = STRB_W'(1);
                base_data = DATA_W'(wdata[7:0]);
            end
            ST_HALF: begin
                base_strb = STRB_W'(2'b11);
                base_data = DATA_W'(wdata[15:0]);
                misalign  = off[0];
            end
            ST_WORD: begin
                base_strb = STRB_W'(4'hF);
                base_data = DATA_W'(wdata[31:0]);
                misalign  = off[1:0] != 2'b00;
            end
            default: rsvd = 1'b1;
        endcase
    end

    assign strb = base_strb << off;
    assign data = base_data << {off, 3'b000};

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store FIFO with memory write port and load-hazard check
// Optional merge into the youngest non-head entry: STORE_BUF_MERGE_EN
module store_buffer
    import store_buf_pkg::*;
#(
    parameter int DATA_W = SB_DATA_W,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         st_valid,
    input  logic                         st_cancel,
    input  logic [1:0]                   st_type,
    input  logic [ADDR_W-1:0]            st_addr,
    input  logic [DATA_W-1:0]            st_wdata,
    output logic                         st_ready,
    output logic                         st_err,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W/8-1:0]          mem_wstrb,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_ack,
    input  logic [ADDR_W-1:0]            ld_addr,
    output logic                         ld_hit,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [STRB_W-1:0] strb_q [DEPTH];
    logic [STRB_W-1:0] strb_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              st_ready_q, st_ready_d;
    logic              st_err_q, st_err_d;
    port_state_e       state_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [STRB_W-1:0] mem_wstrb_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [STRB_W-1:0] fmt_strb;
    logic [DATA_W-1:0] fmt_data;
    logic              fmt_misalign, fmt_rsvd;
    logic [ADDR_W-1:0] st_aligned, ld_aligned;
    logic              legal, accept, push, pop, merge;
    logic              ld_hit_c;
    logic [PTR_W-1:0]  rel;
    logic              unused_ld_lo;

    store_fmt #(.DATA_W(DATA_W)) u_fmt (
        .st_type  (st_type),
        .off      (st_addr[OFF_W-1:0]),
        .wdata    (st_wdata),
        .strb     (fmt_strb),
        .data     (fmt_data),
        .misalign (fmt_misalign),
        .rsvd     (fmt_rsvd)
    );

    assign st_aligned   = {st_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign ld_aligned   = {ld_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign unused_ld_lo = ^ld_addr[OFF_W-1:0];

    assign legal  = !fmt_misalign && !fmt_rsvd;
    assign accept = st_valid && st_ready_q && !st_cancel && legal;
    assign pop    = (state_q == PORT_REQ) && mem_ack;

`ifdef STORE_BUF_MERGE_EN
    logic [PTR_W-1:0] youngest;
    assign youngest = tail_q - PTR_W'(1);
    // The head may already be on the port, so only a younger entry may absorb a store.
    assign merge = accept && (count_q >= CNT_W'(2)) && (addr_q[youngest] == st_aligned);
`else
    assign merge = 1'b0;
`endif
    assign push = accept && !merge;

    always_comb begin
        addr_d  = addr_q;
        strb_d  = strb_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (push) begin
            addr_d[tail_q] = st_aligned;
            strb_d[tail_q] = fmt_strb;
            data_d[tail_q] = fmt_data;
            tail_d         = tail_q + PTR_W'(1);
        end
`ifdef STORE_BUF_MERGE_EN
        if (merge) begin
            strb_d[youngest] = strb_q[youngest] | fmt_strb;
            for (int b = 0; b < STRB_W; b++) begin
                if (fmt_strb[b]) data_d[youngest][8*b +: 8] = fmt_data[8*b +: 8];
            end
        end
`endif
        if (pop) head_d = head_q + PTR_W'(1);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        st_ready_d = count_d != CNT_W'(DEPTH);
        st_err_d   = st_valid && !st_cancel && !legal;
    end

    always_comb begin
        ld_hit_c = accept && (st_aligned == ld_aligned);
        rel      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = PTR_W'(i) - head_q;
            if ((CNT_W'(rel) < count_q) && (addr_q[i] == ld_aligned)) ld_hit_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                strb_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            st_ready_q  <= 1'b1;
            st_err_q    <= 1'b0;
            state_q     <= PORT_IDLE;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            addr_q     <= addr_d;
            strb_q     <= strb_d;
            data_q     <= data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            st_ready_q <= st_ready_d;
            st_err_q   <= st_err_d;
            // Port registers load the next head from the post-update entries.
            case (state_q)
                PORT_IDLE: begin
                    if (count_d != '0) begin
                        state_q     <= PORT_REQ;
                        mem_addr_q  <= addr_d[head_d];
                        mem_wstrb_q <= strb_d[head_d];
                        mem_wdata_q <= data_d[head_d];
                    end
                end
                PORT_REQ: begin
                    if (pop) begin
                        if (count_d != '0) begin
                            mem_addr_q  <= addr_d[head_d];
                            mem_wstrb_q <= strb_d[head_d];
                            mem_wdata_q <= data_d[head_d];
                        end else begin
                            state_q     <= PORT_IDLE;
                            mem_addr_q  <= '0;
                            mem_wstrb_q <= '0;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                default: state_q <= PORT_IDLE;
            endcase
        end
    end

    assign st_ready  = st_ready_q;
    assign st_err    = st_err_q;
    assign mem_req   = (state_q == PORT_REQ);
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
    assign ld_hit    = ld_hit_c;
    assign count     = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed and randomized checks of store_buffer against a queue model
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk, reset;
    logic        st_valid, st_cancel;
    logic [1:0]  st_type;
    logic [31:0] st_addr, st_wdata;
    logic        st_ready, st_err, mem_req, mem_ack, ld_hit;
    logic [31:0] mem_addr, mem_wdata, ld_addr;
    logic [3:0]  mem_wstrb;
    logic [2:0]  count;

    store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_cancel(st_cancel), .st_type(st_type),
        .st_addr(st_addr), .st_wdata(st_wdata),
        .st_ready(st_ready), .st_err(st_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .ld_addr(ld_addr), .ld_hit(ld_hit), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
    } ment_t;

    ment_t q[$];
    logic  exp_err;
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] al(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

    // Store size in bytes from the type code; legality is natural alignment of that size.
    function automatic void fmt(input logic [1:0] t, input logic [31:0] a, input logic [31:0] w,
                                output bit ok, output logic [3:0] s, output logic [31:0] d);
        int sz;
        int off;
        longint m;
        sz  = (t == 2'd0) ? 4 : (t == 2'd1) ? 2 : (t == 2'd2) ? 1 : 0;
        off = int'(a % 4);
        ok  = (sz != 0) && (off % ((sz == 0) ? 1 : sz) == 0);
        s   = 4'(((1 << sz) - 1) << off);
        m   = (64'h1 << (8 * sz)) - 1;
        d   = 32'((64'(w) & m) << (8 * off));
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".st_ready"}, 64'(st_ready), 64'(q.size() < DEPTH));
        chk({tag, ".st_err"}, 64'(st_err), 64'(exp_err));
        chk({tag, ".mem_req"}, 64'(mem_req), 64'(q.size() > 0));
        chk({tag, ".mem_addr"}, 64'(mem_addr), (q.size() > 0) ? 64'(q[0].a) : 64'h0);
        chk({tag, ".mem_wstrb"}, 64'(mem_wstrb), (q.size() > 0) ? 64'(q[0].s) : 64'h0);
        chk({tag, ".mem_wdata"}, 64'(mem_wdata), (q.size() > 0) ? 64'(q[0].d) : 64'h0);
    endtask

    task automatic cyc(input string tag, input logic v, input logic c, input logic [1:0] t,
                       input logic [31:0] a, input logic [31:0] w, input logic ack,
                       input logic [31:0] ld);
        bit          ok, acc, hit, mrg;
        logic [3:0]  s;
        logic [31:0] d;
        int          presize;
        ment_t       e;
        st_valid = v; st_cancel = c; st_type = t; st_addr = a; st_wdata = w;
        mem_ack = ack; ld_addr = ld;
        #1;
        fmt(t, a, w, ok, s, d);
        acc = v && (q.size() < DEPTH) && !c && ok;
        hit = acc && (al(a) == al(ld));
        foreach (q[i]) if (q[i].a == al(ld)) hit = 1'b1;
        chk({tag, ".ld_hit"}, 64'(ld_hit), 64'(hit));
        @(posedge clk);
        presize = q.size();
        mrg = 1'b0;
`ifdef STORE_BUF_MERGE_EN
        if (acc && presize >= 2 && q[presize-1].a == al(a)) mrg = 1'b1;
`endif
        if (mrg) begin
            e = q[presize-1];
            for (int b = 0; b < 4; b++) if (s[b]) e.d[8*b +: 8] = d[8*b +: 8];
            e.s = e.s | s;
            q[presize-1] = e;
        end else if (acc) begin
            e.a = al(a); e.s = s; e.d = d;
            q.push_back(e);
        end
        if (presize > 0 && ack) void'(q.pop_front());
        exp_err = v && !c && !ok;
        #1;
        check_outs(tag);
    endtask

    initial begin
        reset = 1'b1;
        st_valid = 0; st_cancel = 0; st_type = 0; st_addr = 0; st_wdata = 0;
        mem_ack = 0; ld_addr = 0;
        exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        chk("reset.ld_hit", 64'(ld_hit), 64'h0);
        reset = 1'b0;

        // Byte store lands in the top lane.
        cyc("byte", 1, 0, 2'd2, 32'h1003, 32'hAB, 0, 0);
        chk("byte.addr_const", 64'(mem_addr), 64'h1000);
        chk("byte.strb_const", 64'(mem_wstrb), 64'h8);
        chk("byte.data_const", 64'(mem_wdata), 64'hAB000000);
        cyc("byte_ack", 0, 0, 2'd0, 0, 0, 1, 0);
        chk("byte_ack.req_const", 64'(mem_req), 64'h0);

        // Fill to full, fifth store refused, then drain back to back.
        for (int i = 0; i < 5; i++) begin
            cyc("fill", 1, 0, 2'd0, 32'h10 + 32'(4 * i), 32'h100 + 32'(i), 0, 0);
            if (i == 3) chk("fill.ready_const", 64'(st_ready), 64'h0);
        end
        chk("fill.count_const", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("drain.addr_const", 64'(mem_addr), 64'h10 + 64'(4 * i));
            cyc("drain", 0, 0, 2'd0, 0, 0, 1, 0);
        end
        chk("drain.count_const", 64'(count), 64'd0);

        // Full with a same-cycle ack still refuses the store.
        for (int i = 0; i < 4; i++) cyc("refill", 1, 0, 2'd0, 32'h40 + 32'(4 * i), 32'(i), 0, 0);
        cyc("full_ack", 1, 0, 2'd0, 32'h80, 32'h5, 1, 0);
        chk("full_ack.count_const", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) cyc("full_drain", 0, 0, 2'd0, 0, 0, 1, 0);

        // Rejected and cancelled stores.
        cyc("misalign", 1, 0, 2'd1, 32'h2001, 32'h1234, 0, 0);
        chk("misalign.err_const", 64'(st_err), 64'h1);
        cyc("err_clear", 0, 0, 2'd0, 0, 0, 0, 0);
        chk("err_clear.err_const", 64'(st_err), 64'h0);
        cyc("rsvd", 1, 0, 2'd3, 32'h2000, 32'h1, 0, 0);
        cyc("cancel", 1, 1, 2'd2, 32'h2000, 32'h1, 0, 0);
        chk("cancel.err_const", 64'(st_err), 64'h0);

        // Load hazard against a pending word.
        cyc("hz_st", 1, 0, 2'd0, 32'h3004, 32'hDEAD, 0, 32'h3006);
        cyc("hz_hold", 0, 0, 2'd0, 0, 0, 0, 32'h3006);
        ld_addr = 32'h3006; #1;
        chk("hz.hit_const", 64'(ld_hit), 64'h1);
        cyc("hz_ack", 0, 0, 2'd0, 0, 0, 1, 32'h3006);
        chk("hz.clear_const", 64'(ld_hit), 64'h0);

        // Merge candidate behind a held head.
        cyc("mg_head", 1, 0, 2'd2, 32'h100, 32'h55, 0, 0);
        cyc("mg_b0", 1, 0, 2'd2, 32'h204, 32'h11, 0, 0);
        cyc("mg_b1", 1, 0, 2'd2, 32'h205, 32'h22, 0, 0);
`ifdef STORE_BUF_MERGE_EN
        chk("mg.count_const", 64'(count), 64'd2);
        cyc("mg_pop", 0, 0, 2'd0, 0, 0, 1, 0);
        chk("mg.strb_const", 64'(mem_wstrb), 64'h3);
        chk("mg.data_const", 64'(mem_wdata), 64'h00002211);
`else
        chk("mg.count_const", 64'(count), 64'd3);
        cyc("mg_pop", 0, 0, 2'd0, 0, 0, 1, 0);
        chk("mg.strb_const", 64'(mem_wstrb), 64'h1);
        chk("mg.data_const", 64'(mem_wdata), 64'h00000011);
`endif
        while (q.size() > 0) cyc("mg_drain", 0, 0, 2'd0, 0, 0, 1, 0);

        // Asynchronous reset mid-queue.
        for (int i = 0; i < 3; i++) cyc("rs_fill", 1, 0, 2'd0, 32'h500 + 32'(4 * i), 32'(i), 0, 0);
        reset = 1'b1;
        #1;
        chk("async_rst.mem_req", 64'(mem_req), 64'h0);
        chk("async_rst.count", 64'(count), 64'h0);
        q.delete();
        exp_err = 1'b0;
        #1;
        reset = 1'b0;
        cyc("post_rst_st", 1, 0, 2'd1, 32'h602, 32'hBEEF, 0, 0);
        cyc("post_rst_ack", 0, 0, 2'd0, 0, 0, 1, 0);

        // Randomized traffic over a small address window to provoke hits and merges.
        for (int n = 0; n < 400; n++) begin
            cyc("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                2'($urandom_range(0, 3)), 32'h400 + 32'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 2) == 0, 32'h400 + 32'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
